gpu_raster_timing: RTL and testbench

Raster scan generator for the scope display pipeline. It produces the `row`/`col` pixel coordinates that every GPU overlay layer consumes (graticule, trace, cursor). It also produces the monitor sync, the blanking flag, and the line/frame strobes. It is the driving end of the row/col interface: layers stay purely combinational, and this block owns all raster timing. Defaults give 800x600 @ 72 Hz from a 50 MHz pixel clock.

---
 rtl/gpu_raster_timing.sv | 133 +++++++++++++
 tb/tb_gpu_raster_timing.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gpu_raster_timing.sv
// Raster scan generator: pixel divider, h/v counters, registered coordinates,
// syncs and strobes, plus an optional delay line on visible/hsync/vsync.
module gpu_raster_timing #(
  parameter int H_VISIBLE  = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_VISIBLE  = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CLK_DIV    = 1,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       visible_d,
  output logic       hsync_d,
  output logic       vsync_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0]  r_div, w_div_next;
  logic [10:0] r_h, r_v, w_h_next, w_v_next;
  logic        r_run;
  logic        w_vis, w_hs, w_vs, w_tick, w_h_zero, w_v_zero;

  // Counters always describe the pixel being shown; the first enabled cycle
  // after idle/reset shows (0,0) without advancing.
  always_comb begin
    w_div_next = r_div;
    w_h_next   = r_h;
    w_v_next   = r_v;
    if (!enable) begin
      w_div_next = '0;
      w_h_next   = '0;
      w_v_next   = '0;
    end else if (r_run) begin
      if (r_div == DIV_LAST) begin
        w_div_next = '0;
        if (r_h == H_LAST) begin
          w_h_next = '0;
          w_v_next = (r_v == V_LAST) ? 11'd0 : r_v + 11'd1;
        end else begin
          w_h_next = r_h + 11'd1;
        end
      end else begin
        w_div_next = r_div + 2'd1;
      end
    end
  end

  assign w_vis    = enable && (w_h_next < H_VIS) && (w_v_next < V_VIS);
  assign w_hs     = enable && (w_h_next >= HS_BEG) && (w_h_next < HS_END);
  assign w_vs     = enable && (w_v_next >= VS_BEG) && (w_v_next < VS_END);
  assign w_tick   = enable && (w_div_next == DIV_LAST);
  assign w_h_zero = (w_h_next == 11'd0);
  assign w_v_zero = (w_v_next == 11'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_div       <= '0;
      r_h         <= '0;
      r_v         <= '0;
      col         <= '0;
      row         <= '0;
      visible     <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_run       <= enable;
      r_div       <= w_div_next;
      r_h         <= w_h_next;
      r_v         <= w_v_next;
      col         <= w_vis ? w_h_next[9:0] : 10'd0;
      row         <= w_vis ? w_v_next[9:0] : 10'd0;
      visible     <= w_vis;
      hsync       <= w_hs ? HS_POL : ~HS_POL;
      vsync       <= w_vs ? VS_POL : ~VS_POL;
      pix_tick    <= w_tick;
      line_start  <= w_tick && w_h_zero;
      frame_start <= w_tick && w_h_zero && w_v_zero;
    end
  end

  // Delay line runs on every clk so it tracks downstream pipeline stages.
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign visible_d = visible;
      assign hsync_d   = hsync;
      assign vsync_d   = vsync;
    end else begin : g_dly
      localparam logic [2:0] IDLE = {1'b0, ~HS_POL, ~VS_POL};
      logic [2:0] r_stage [SYNC_DELAY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_DELAY; i++) r_stage[i] <= IDLE;
        end else begin
          r_stage[0] <= {visible, hsync, vsync};
          for (int i = 1; i < SYNC_DELAY; i++) r_stage[i] <= r_stage[i-1];
        end
      end
      assign {visible_d, hsync_d, vsync_d} = r_stage[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_gpu_raster_timing.sv
// Randomized enable/reset stimulus on three raster configurations, checked
// cycle by cycle against an arithmetic model of the scan position.
module tb_gpu_raster_timing;

  localparam int HV = 20, HF = 3, HSW = 4, HB = 5;
  localparam int VV = 10, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;
  logic a_vis, a_hs, a_vs, a_tick, a_ls, a_fs, a_vd, a_hd, a_vsd;
  logic b_vis, b_hs, b_vs, b_tick, b_ls, b_fs, b_vd, b_hd, b_vsd;
  logic c_vis, c_hs, c_vs, c_tick, c_ls, c_fs, c_vd, c_hd, c_vsd;

  gpu_raster_timing #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .SYNC_DELAY(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .col(a_col), .row(a_row),
    .visible(a_vis), .hsync(a_hs), .vsync(a_vs), .pix_tick(a_tick),
    .line_start(a_ls), .frame_start(a_fs), .visible_d(a_vd),
    .hsync_d(a_hd), .vsync_d(a_vsd));

  gpu_raster_timing #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(2), .SYNC_DELAY(3)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .col(b_col), .row(b_row),
    .visible(b_vis), .hsync(b_hs), .vsync(b_vs), .pix_tick(b_tick),
    .line_start(b_ls), .frame_start(b_fs), .visible_d(b_vd),
    .hsync_d(b_hd), .vsync_d(b_vsd));

  gpu_raster_timing #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .SYNC_DELAY(0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .col(c_col), .row(c_row),
    .visible(c_vis), .hsync(c_hs), .vsync(c_vs), .pix_tick(c_tick),
    .line_start(c_ls), .frame_start(c_fs), .visible_d(c_vd),
    .hsync_d(c_hd), .vsync_d(c_vsd));

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic vis, hs, vs, tick, ls, fs;
  } exp_t;

  int errors = 0;
  int checks = 0;
  int t_a, t_b, t_c;
  int cyc = 0;
  int last_fs_a = -1;
  int last_ls_c = -1;
  logic [2:0] hist [3][4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scan position from elapsed cycles since the scan (re)started; t<0 = idle.
  function automatic exp_t model(input int t, input int dv, input bit hp, input bit vp);
    exp_t e;
    int p, h, v;
    e = '0;
    e.hs = !hp;
    e.vs = !vp;
    if (t >= 0) begin
      p = t / dv;
      h = p % HT;
      v = (p / HT) % VT;
      e.vis  = (h < HV) && (v < VV);
      e.col  = e.vis ? 10'(h) : 10'd0;
      e.row  = e.vis ? 10'(v) : 10'd0;
      e.hs   = (h >= HV + HF && h < HV + HF + HSW) ? hp : !hp;
      e.vs   = (v >= VV + VF && v < VV + VF + VSW) ? vp : !vp;
      e.tick = (t % dv) == dv - 1;
      e.ls   = e.tick && (h == 0);
      e.fs   = e.ls && (v == 0);
    end
    return e;
  endfunction

  task automatic reset_model();
    t_a = -1; t_b = -1; t_c = -1;
    last_fs_a = -1;
    last_ls_c = -1;
    for (int i = 0; i < 4; i++) begin
      hist[0][i] = 3'b000;
      hist[1][i] = 3'b010;
      hist[2][i] = 3'b001;
    end
  endtask

  task automatic check_dut(input int k, input string nm, input int t, input int dv,
                           input int sd, input bit hp, input bit vp, input bit at_edge,
                           input logic [9:0] col, input logic [9:0] row,
                           input logic vis, input logic hs, input logic vs,
                           input logic tick, input logic ls, input logic fs,
                           input logic vd, input logic hd, input logic vsd);
    exp_t e;
    logic [2:0] ed;
    e = model(t, dv, hp, vp);
    check_val({nm, ".col"}, 32'(col), 32'(e.col));
    check_val({nm, ".row"}, 32'(row), 32'(e.row));
    check_val({nm, ".visible"}, 32'(vis), 32'(e.vis));
    check_val({nm, ".hsync"}, 32'(hs), 32'(e.hs));
    check_val({nm, ".vsync"}, 32'(vs), 32'(e.vs));
    check_val({nm, ".pix_tick"}, 32'(tick), 32'(e.tick));
    check_val({nm, ".line_start"}, 32'(ls), 32'(e.ls));
    check_val({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
    ed = (sd == 0) ? {e.vis, e.hs, e.vs} : hist[k][sd-1];
    check_val({nm, ".visible_d"}, 32'(vd), 32'(ed[2]));
    check_val({nm, ".hsync_d"}, 32'(hd), 32'(ed[1]));
    check_val({nm, ".vsync_d"}, 32'(vsd), 32'(ed[0]));
    if (at_edge) begin
      for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = {e.vis, e.hs, e.vs};
    end
  endtask

  task automatic check_all(input bit at_edge);
    check_dut(0, "a", t_a, 1, 1, 1'b1, 1'b1, at_edge, a_col, a_row, a_vis, a_hs, a_vs,
              a_tick, a_ls, a_fs, a_vd, a_hd, a_vsd);
    check_dut(1, "b", t_b, 2, 3, 1'b0, 1'b1, at_edge, b_col, b_row, b_vis, b_hs, b_vs,
              b_tick, b_ls, b_fs, b_vd, b_hd, b_vsd);
    check_dut(2, "c", t_c, 3, 0, 1'b1, 1'b0, at_edge, c_col, c_row, c_vis, c_hs, c_vs,
              c_tick, c_ls, c_fs, c_vd, c_hd, c_vsd);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) begin
      reset_model();
    end else if (enable) begin
      t_a++; t_b++; t_c++;
    end else begin
      t_a = -1; t_b = -1; t_c = -1;
      last_fs_a = -1;
      last_ls_c = -1;
    end
    #1;
    check_all(1'b1);
    if (a_fs) begin
      if (last_fs_a >= 0) check_val("a.frame_period", 32'(cyc - last_fs_a), 32'(HT * VT));
      last_fs_a = cyc;
    end
    if (c_ls) begin
      if (last_ls_c >= 0) check_val("c.line_period", 32'(cyc - last_ls_c), 32'(HT * 3));
      last_ls_c = cyc;
    end
  endtask

  // Reset is raised between edges; outputs must clear before the next edge.
  task automatic async_rst(input int n);
    rst = 1'b1;
    #1;
    reset_model();
    check_all(1'b0);
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    reset_model();
    repeat (5) step();
    rst = 1'b0;
    repeat (100) step();
    enable = 1'b1;
    repeat (3500) step();
    for (int s = 0; s < 16; s++) begin
      repeat ($urandom_range(40, 1600)) step();
      case ($urandom_range(0, 2))
        0: begin
          enable = 1'b0;
          repeat ($urandom_range(1, 6)) step();
          enable = 1'b1;
        end
        1: async_rst($urandom_range(1, 3));
        default: begin
          enable = 1'b0;
          async_rst(2);
          repeat (3) step();
          enable = 1'b1;
        end
      endcase
    end
    repeat (200) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
